// File: rtl/serial_word_collector_pkg.sv
// Shared state encoding and handshake naming for the serial collector and its neighbours.
// Pure declarations: no latency, no backpressure.
package serial_word_collector_pkg;

    localparam logic STATE_FILL = 1'b0;
    localparam logic STATE_HOLD = 1'b1;

    typedef enum logic {
        ST_FILL = STATE_FILL,
        ST_HOLD = STATE_HOLD
    } state_e;

    // A transfer happens on any cycle where the producer is valid and the consumer ready.
    function automatic logic hs_fire(input logic vld, input logic rdy);
        return vld & rdy;
    endfunction

endpackage

// File: rtl/serial_word_collector_bit_counter.sv
// Bit position counter for one word; updates the cycle after inc_i, terminal_o is combinational.
// No backpressure; zero_i overrides inc_i, and inc_i at the terminal count wraps to zero.
module serial_word_collector_bit_counter
    import serial_word_collector_pkg::*;
#(
    parameter int COUNT_WIDTH = 4,
    parameter int INPUT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   zero_i,
    input  logic                   inc_i,
    output logic [COUNT_WIDTH-1:0] count_o,
    output logic                   terminal_o
);

    localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(INPUT_WIDTH - 1);

    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;

    assign terminal_o = (count_q == LAST);
    assign count_o    = count_q;

    always_comb begin
        count_d = count_q;
        if (zero_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = terminal_o ? '0 : count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serial_word_collector.sv
// Serial-to-parallel word collector; outputValid rises 1 cycle after the last bit is accepted.
// serialReady drops while a word is held; the held word waits indefinitely for outputReady.
module serial_word_collector
    import serial_word_collector_pkg::*;
#(
    parameter int INPUT_WIDTH = 8,
    parameter bit LSB_FIRST   = 1'b1,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   clear,
    input  logic                   serialData,
    input  logic                   serialValid,
    output logic                   serialReady,
    output logic [INPUT_WIDTH-1:0] outputData,
    output logic                   outputValid,
    input  logic                   outputReady,
    output logic [COUNT_WIDTH-1:0] bitCount
);

    state_e                 state_q;
    logic [INPUT_WIDTH-1:0] data_q;
    logic [INPUT_WIDTH-1:0] data_d;
    logic                   accept;
    logic                   handoff;
    logic                   last_bit;

    // Handshake outputs decode from the state register only, so they never glitch on inputs.
    assign serialReady = (state_q == ST_FILL);
    assign outputValid = (state_q == ST_HOLD);
    assign outputData  = data_q;

    assign accept  = hs_fire(serialValid, serialReady);
    assign handoff = hs_fire(outputValid, outputReady);

    generate
        if (INPUT_WIDTH == 1) begin : g_single
            assign data_d = serialData;
        end else if (LSB_FIRST) begin : g_lsb_first
            assign data_d = {serialData, data_q[INPUT_WIDTH-1:1]};
        end else begin : g_msb_first
            assign data_d = {data_q[INPUT_WIDTH-2:0], serialData};
        end
    endgenerate

    serial_word_collector_bit_counter #(
        .COUNT_WIDTH(COUNT_WIDTH),
        .INPUT_WIDTH(INPUT_WIDTH)
    ) u_bit_counter (
        .clock      (clock),
        .resetN     (resetN),
        .zero_i     (clear),
        .inc_i      (accept),
        .count_o    (bitCount),
        .terminal_o (last_bit)
    );

    always_ff @(posedge clock) begin
        if (!resetN || clear) begin
            state_q <= ST_FILL;
            data_q  <= '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (accept) begin
                        data_q <= data_d;
                        if (last_bit) begin
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (handoff) begin
                        state_q <= ST_FILL;
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_collector.sv
// Bench for serial_word_collector: 4-bit LSB/MSB-first instances share stimulus, a 1-bit instance
// covers single-bit words; expected words go through queues and are popped when outputValid shows.
module tb_serial_word_collector;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic resetN, clear, sdat, svld, ordy;
    logic [3:0] a_data, b_data, a_cnt, b_cnt, c_cnt;
    logic [0:0] c_data;
    logic       a_vld, a_srdy, b_vld, b_srdy, c_vld, c_srdy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_a[$];
    logic [3:0] exp_b[$];
    logic       exp_c[$];
    logic [3:0] held_a, held_b;

    serial_word_collector #(.INPUT_WIDTH(4), .LSB_FIRST(1'b1), .COUNT_WIDTH(4)) dut_a (
        .clock(clock), .resetN(resetN), .clear(clear), .serialData(sdat), .serialValid(svld),
        .serialReady(a_srdy), .outputData(a_data), .outputValid(a_vld), .outputReady(ordy),
        .bitCount(a_cnt));

    serial_word_collector #(.INPUT_WIDTH(4), .LSB_FIRST(1'b0), .COUNT_WIDTH(4)) dut_b (
        .clock(clock), .resetN(resetN), .clear(clear), .serialData(sdat), .serialValid(svld),
        .serialReady(b_srdy), .outputData(b_data), .outputValid(b_vld), .outputReady(ordy),
        .bitCount(b_cnt));

    serial_word_collector #(.INPUT_WIDTH(1), .LSB_FIRST(1'b1), .COUNT_WIDTH(4)) dut_c (
        .clock(clock), .resetN(resetN), .clear(clear), .serialData(sdat), .serialValid(svld),
        .serialReady(c_srdy), .outputData(c_data), .outputValid(c_vld), .outputReady(ordy),
        .bitCount(c_cnt));

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // bits[i] is the i-th bit sent on the serial line.
    task automatic push_word(input logic [3:0] bits);
        logic [3:0] wa, wb;
        for (int i = 0; i < 4; i++) begin
            wa[i]     = bits[i];
            wb[3 - i] = bits[i];
        end
        exp_a.push_back(wa);
        exp_b.push_back(wb);
    endtask

    task automatic send_bits(input logic [3:0] bits, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            sdat = bits[i];
            svld = 1'b1;
            step();
        end
        svld = 1'b0;
        sdat = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0; clear = 1'b0; svld = 1'b0; sdat = 1'b0; ordy = 1'b0;
        step(); step();
        resetN = 1'b1;
        step();
        n_tests++; if (a_vld !== 1'b0)   begin n_fail++; $display("FAIL reset_vld got %b want 0", a_vld); end
        n_tests++; if (a_srdy !== 1'b1)  begin n_fail++; $display("FAIL reset_srdy got %b want 1", a_srdy); end
        n_tests++; if (a_data !== 4'h0)  begin n_fail++; $display("FAIL reset_data got %h want 0", a_data); end
        n_tests++; if (a_cnt !== 4'd0)   begin n_fail++; $display("FAIL reset_cnt got %0d want 0", a_cnt); end
        n_tests++; if (b_vld !== 1'b0)   begin n_fail++; $display("FAIL reset_b_vld got %b want 0", b_vld); end
    endtask

    task automatic test_basic();
        logic [3:0] ea, eb;
        push_word(4'b1101);
        send_bits(4'b1101, 0, 1);
        n_tests++; if (a_cnt !== 4'd2) begin n_fail++; $display("FAIL basic_cnt2 got %0d want 2", a_cnt); end
        send_bits(4'b1101, 2, 2);
        n_tests++; if (a_vld !== 1'b0) begin n_fail++; $display("FAIL basic_early_vld got %b want 0", a_vld); end
        send_bits(4'b1101, 3, 3);
        n_tests++; if (a_vld !== 1'b1)  begin n_fail++; $display("FAIL basic_vld got %b want 1", a_vld); end
        n_tests++; if (a_srdy !== 1'b0) begin n_fail++; $display("FAIL basic_srdy got %b want 0", a_srdy); end
        n_tests++; if (a_cnt !== 4'd0)  begin n_fail++; $display("FAIL basic_cnt got %0d want 0", a_cnt); end
        n_tests++; if (b_vld !== 1'b1)  begin n_fail++; $display("FAIL basic_b_vld got %b want 1", b_vld); end
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        n_tests++; if (a_data !== ea) begin n_fail++; $display("FAIL basic_lsb_data got %b want %b", a_data, ea); end
        n_tests++; if (b_data !== eb) begin n_fail++; $display("FAIL basic_msb_data got %b want %b", b_data, eb); end
        held_a = ea;
        held_b = eb;
    endtask

    task automatic test_hold();
        ordy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            svld = 1'b1;
            sdat = 1'($urandom_range(0, 1));
            step();
            n_tests++; if (a_data !== held_a) begin n_fail++; $display("FAIL hold_data_a cyc %0d got %b want %b", i, a_data, held_a); end
            n_tests++; if (b_data !== held_b) begin n_fail++; $display("FAIL hold_data_b cyc %0d got %b want %b", i, b_data, held_b); end
            n_tests++; if (a_vld !== 1'b1 || a_cnt !== 4'd0) begin n_fail++; $display("FAIL hold_state cyc %0d vld %b cnt %0d want 1/0", i, a_vld, a_cnt); end
        end
        svld = 1'b0; sdat = 1'b0; ordy = 1'b1;
        step();
        ordy = 1'b0;
        n_tests++; if (a_vld !== 1'b0)  begin n_fail++; $display("FAIL handoff_vld got %b want 0", a_vld); end
        n_tests++; if (a_srdy !== 1'b1) begin n_fail++; $display("FAIL handoff_srdy got %b want 1", a_srdy); end
        n_tests++; if (b_vld !== 1'b0)  begin n_fail++; $display("FAIL handoff_b_vld got %b want 0", b_vld); end
        n_tests++; if (a_cnt !== 4'd0)  begin n_fail++; $display("FAIL handoff_cnt got %0d want 0", a_cnt); end
    endtask

    task automatic test_clear();
        logic [3:0] ea, eb;
        send_bits(4'b0011, 0, 1);
        n_tests++; if (a_cnt !== 4'd2) begin n_fail++; $display("FAIL clear_pre_cnt got %0d want 2", a_cnt); end
        clear = 1'b1; svld = 1'b1; sdat = 1'b1;
        step();
        clear = 1'b0; svld = 1'b0; sdat = 1'b0;
        n_tests++; if (a_cnt !== 4'd0)  begin n_fail++; $display("FAIL clear_cnt got %0d want 0", a_cnt); end
        n_tests++; if (a_data !== 4'h0) begin n_fail++; $display("FAIL clear_data got %b want 0000", a_data); end
        n_tests++; if (a_srdy !== 1'b1 || a_vld !== 1'b0) begin n_fail++; $display("FAIL clear_state srdy %b vld %b want 1/0", a_srdy, a_vld); end
        push_word(4'b0110);
        send_bits(4'b0110, 0, 3);
        n_tests++; if (a_vld !== 1'b1) begin n_fail++; $display("FAIL clear_word_vld got %b want 1", a_vld); end
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        n_tests++; if (a_data !== ea) begin n_fail++; $display("FAIL clear_word_a got %b want %b", a_data, ea); end
        n_tests++; if (b_data !== eb) begin n_fail++; $display("FAIL clear_word_b got %b want %b", b_data, eb); end
        ordy = 1'b1; step(); ordy = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] ea, eb;
        send_bits(4'b1111, 0, 3);
        n_tests++; if (a_vld !== 1'b1) begin n_fail++; $display("FAIL rst_hold_pre_vld got %b want 1", a_vld); end
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        n_tests++; if (a_vld !== 1'b0)  begin n_fail++; $display("FAIL rst_hold_vld got %b want 0", a_vld); end
        n_tests++; if (a_data !== 4'h0) begin n_fail++; $display("FAIL rst_hold_data got %b want 0000", a_data); end
        n_tests++; if (a_srdy !== 1'b1) begin n_fail++; $display("FAIL rst_hold_srdy got %b want 1", a_srdy); end
        send_bits(4'b0001, 0, 0);
        n_tests++; if (a_cnt !== 4'd1) begin n_fail++; $display("FAIL rst_mid_pre_cnt got %0d want 1", a_cnt); end
        resetN = 1'b0; svld = 1'b1; sdat = 1'b1;
        step();
        resetN = 1'b1; svld = 1'b0; sdat = 1'b0;
        n_tests++; if (a_cnt !== 4'd0)  begin n_fail++; $display("FAIL rst_drop_cnt got %0d want 0", a_cnt); end
        n_tests++; if (a_data !== 4'h0) begin n_fail++; $display("FAIL rst_drop_data got %b want 0000", a_data); end
        push_word(4'b0011);
        send_bits(4'b0011, 0, 3);
        n_tests++; if (a_vld !== 1'b1) begin n_fail++; $display("FAIL rst_word_vld got %b want 1", a_vld); end
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        n_tests++; if (a_data !== ea) begin n_fail++; $display("FAIL rst_word_a got %b want %b", a_data, ea); end
        n_tests++; if (b_data !== eb) begin n_fail++; $display("FAIL rst_word_b got %b want %b", b_data, eb); end
        ordy = 1'b1; step(); ordy = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  idx = 0;
        int  seen = 0;
        int  last_cyc = 0;
        logic accepted;
        logic ec;
        resetN = 1'b0; svld = 1'b0;
        step();
        resetN = 1'b1;
        ordy = 1'b1;
        exp_c.push_back(1'b1);
        exp_c.push_back(1'b0);
        for (int cyc = 0; cyc < 20 && seen < 2; cyc++) begin
            svld = (idx < 2);
            sdat = (idx == 0);
            accepted = svld && c_srdy;
            step();
            if (accepted) idx++;
            n_tests++; if (c_cnt !== 4'd0) begin n_fail++; $display("FAIL w1_cnt cyc %0d got %0d want 0", cyc, c_cnt); end
            if (c_vld === 1'b1) begin
                ec = exp_c.pop_front();
                n_tests++; if (c_data[0] !== ec) begin n_fail++; $display("FAIL w1_data word %0d got %b want %b", seen, c_data[0], ec); end
                if (seen > 0) begin
                    n_tests++; if (cyc - last_cyc != 2) begin n_fail++; $display("FAIL w1_spacing got %0d want 2", cyc - last_cyc); end
                end
                last_cyc = cyc;
                seen++;
            end
        end
        svld = 1'b0; ordy = 1'b0;
        n_tests++; if (seen != 2) begin n_fail++; $display("FAIL w1_timeout got %0d words want 2", seen); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0; clear = 1'b0; sdat = 1'b0; svld = 1'b0; ordy = 1'b0;
        held_a = '0; held_b = '0;
        test_reset();
        test_basic();
        test_hold();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        n_tests++; if (exp_a.size() != 0 || exp_b.size() != 0) begin n_fail++; $display("FAIL leftover_words got %0d/%0d want 0/0", exp_a.size(), exp_b.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
